// File: rtl/pot_paddle_emu.sv
`default_nettype none
// ============================================================================
//  Module   : pot_paddle_emu
//  Purpose  : Emulates one POKEY paddle line by raising pot_in at the scan
//             count equal to a programmed position, tracking POTGO timing.
//  Revision : 1.0  initial release
// ============================================================================
module pot_paddle_emu #(
    parameter int ARM_DELAY = 16,
    parameter int MIN_COUNT = 5,
    parameter int MAX_COUNT = 228
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       POTGO,
    input  logic [7:0] pot_value,
    input  logic       pot_we,
    input  logic       pot_enable,
    output logic       pot_in,
    output logic       scan_done,
    output logic [7:0] cur_target,
    output logic [1:0] emu_state
);

    localparam logic [7:0] c_arm_delay = 8'(ARM_DELAY);
    localparam logic [7:0] c_min_count = 8'(MIN_COUNT);
    localparam logic [7:0] c_max_count = 8'(MAX_COUNT);
    localparam logic [7:0] c_min_m1    = 8'(MIN_COUNT - 1);
    localparam logic [7:0] c_max_m1    = 8'(MAX_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_shadow;
    logic       r_open;

    logic [7:0] w_value;
    logic [7:0] w_clamped;
    logic       w_open;
    logic [7:0] w_cnt_inc;
    logic       w_exit;

    // A write on the scan-entry edge must win over the stale shadow value.
    assign w_value   = pot_we ? pot_value : r_shadow;
    assign w_clamped = (w_value < c_min_count) ? c_min_count : w_value;
    assign w_open    = !pot_enable || (w_value > c_max_count);
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_exit    = (r_cnt > c_min_m1) && (pot_in || (r_cnt > c_max_m1));

    assign emu_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_shadow   <= 8'd0;
            r_open     <= 1'b0;
            cur_target <= c_min_count;
            pot_in     <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (pot_we) begin
                r_shadow <= pot_value;
            end
            case (r_state)
                S_SCAN: begin
                    if (w_exit) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 8'd0;
                        pot_in    <= 1'b0;
                        scan_done <= 1'b1;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        // Looking at the next count puts pot_in high in the cycle cnt equals T.
                        pot_in <= !r_open && (w_cnt_inc >= cur_target);
                    end
                end
                default: begin
                    pot_in <= 1'b0;
                    if (!POTGO) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt <= c_arm_delay) begin
                        r_state <= S_ARM;
                        r_cnt   <= w_cnt_inc;
                    end else begin
                        r_state    <= S_SCAN;
                        r_cnt      <= 8'd0;
                        r_open     <= w_open;
                        cur_target <= w_open ? c_max_count : w_clamped;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pot_paddle_emu.md
Name: pot_paddle_emu

Overview:
- Emulates one POKEY paddle/potentiometer line: the charge-side partner of the pot scan FSM.
- Watches the shared POTGO strobe and tracks the scanner's arm/scan timeline cycle-for-cycle.
- Drives pot_in high at the scan count equal to a programmed paddle position, so the scanner's POTOUT captures that position.
- Sits in the POKEY IO group; pot_value comes from the controller/host side (joystick/USB adaptor logic).

Parameters:
ARM_DELAY, 16, POTGO-high count that must be exceeded before a scan starts (scan starts once arm count > ARM_DELAY)
MIN_COUNT, 5, smallest scan count the scanner accepts pot_in at
MAX_COUNT, 228, scanner timeout count; result when the line never charges

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
POTGO  input  1  shared pot-scan request, same signal the scanner sees
pot_value  input  8  requested paddle position
pot_we  input  1  write strobe: shadow <= pot_value
pot_enable  input  1  paddle connected; 0 = open line, pot_in never rises
pot_in  output  1  emulated charge-comparator output to scanner, registered
scan_done  output  1  one-cycle pulse when the emulated scan ends
cur_target  output  8  target latched for the current/last scan
emu_state  output  2  0=IDLE, 1=ARM, 2=SCAN

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE, cnt=0, shadow=0, cur_target=MIN_COUNT, pot_in=0, scan_done=0. Reset mid-scan aborts immediately; pot_in drops at that edge.
- shadow register: loads pot_value on any posedge with pot_we=1, in any state.
- Target: T = clamp(v) where v = (pot_we ? pot_value : shadow), sampled at the scan-entry edge (write-bypass on the same cycle).
  - v < MIN_COUNT -> T = MIN_COUNT.
  - v > MAX_COUNT or pot_enable=0 at entry -> open line: pot_in stays 0 for the whole scan; cur_target = MAX_COUNT.
  - Otherwise T = v.
- Internal cnt is 8-bit and mirrors the scanner timer exactly.
- IDLE/ARM (pot_in=0, capacitor dumped):
  - POTGO=0 -> cnt<=0, state IDLE.
  - POTGO=1 and cnt<=ARM_DELAY -> cnt<=cnt+1, state ARM.
  - POTGO=1 and cnt>ARM_DELAY -> cnt<=0, state SCAN, latch T into cur_target.
  - POTGO dropping at any ARM cycle (including cnt=ARM_DELAY+1) -> back to IDLE with cnt=0; no scan.
  - Scan entry is the 18th consecutive POTGO-high posedge.
- SCAN:
  - cnt increments every posedge. POTGO is ignored; dropping it does not abort.
  - pot_in=1 during every SCAN cycle with cnt>=T (non-open line). It is registered from the next-count value, so it is high in the same cycle cnt first equals T.
  - Exit condition, evaluated on current values: cnt>MIN_COUNT-1 and (pot_in or cnt>MAX_COUNT-1).
  - On the following posedge: state IDLE, cnt<=0, pot_in<=0, scan_done<=1 for one cycle.
  - The scanner therefore captures POTOUT = T, or MAX_COUNT for an open line.
- Back-to-back: if POTGO is still high after exit, re-arm starts from cnt=0. The next scan uses a fresh T, so shadow writes made mid-scan apply only to the next scan.
- cnt never wraps: ARM stops at ARM_DELAY+1 and SCAN exits by MAX_COUNT.

Test Plan:
- Basic: pot_we with pot_value=100, then POTGO held -> SCAN entered on the 18th POTGO edge; pot_in rises when cnt=100; scan_done one cycle later; paired scanner POTOUT=100.
- Clamp: value 2 -> pot_in high at cnt=5, POTOUT=5. Value 240 or pot_enable=0 -> pot_in stays 0, exit after cnt=228, POTOUT=228, cur_target=228.
- Arm abort: POTGO high for 10 cycles, then low -> returns to IDLE, cnt=0, no SCAN, pot_in 0. POTGO high again -> needs a full 18 edges.
- Mid-scan write: scan at 50, pot_we=200 at cnt=20 -> current scan ends at 50. With POTGO held, the next scan ends at 200. Also: write on the entry edge -> bypass value used.
- Reset at cnt=30 in SCAN -> next cycle IDLE, pot_in=0, scan_done=0, shadow=0.
- POTGO dropped mid-scan -> scan still completes at T, scan_done pulses, then stays IDLE.
